// File: rtl/uar_ovs.sv
// UART receiver: 16x oversampling, configurable frame format, break detection and a FWFT output FIFO.
// Optional macro UAR_OVS_MAJORITY_EN: three-sample majority vote (s = 7, 8, 9) instead of a single sample at s = 8.
module uar_ovs #(
    parameter real CLK_FREQ   = 100e6,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1,
    parameter int  FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_perr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          framing_error,
    output logic                          overrun,
    output logic                          break_detect,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam real         INC_R     = 16777216.0 * 16.0 * BAUD_RATE / CLK_FREQ;
    localparam logic [23:0] INC       = 24'($rtoi(INC_R + 0.5));
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [AW:0] FULL_LVL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    (* ASYNC_REG = "TRUE" *) logic rx_meta_reg;
    (* ASYNC_REG = "TRUE" *) logic rx_sync_reg;
    logic rx_prev_reg;

    state_t                 state_reg, state_next;
    logic [23:0]            acc_reg, acc_next;
    logic [24:0]            acc_sum;
    logic [3:0]             s_reg, s_next, s_inc;
    logic [3:0]             bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]   data_reg, data_next;
    logic                   xor_reg, xor_next;
    logic                   ones_reg, ones_next;
    logic                   brk_hi_reg, brk_hi_next;
    logic                   tick, decide, bit_val, perr;
    logic                   push, fe_next, bd_next;
    logic                   framing_error_reg, break_detect_reg, overrun_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // Oversample tick is the carry-out of the phase accumulator
    assign acc_sum = {1'b0, acc_reg} + {1'b0, INC};
    assign tick    = acc_sum[24] && (state_reg != IDLE);
    assign acc_next = (state_reg == IDLE) ? 24'd0 : acc_sum[23:0];
    assign s_inc   = s_reg + 4'd1;

`ifdef UAR_OVS_MAJORITY_EN
    logic [1:0] samp_reg, samp_next;

    always_comb begin
        samp_next = samp_reg;
        if (tick && s_inc == 4'd7) samp_next[0] = rx_sync_reg;
        if (tick && s_inc == 4'd8) samp_next[1] = rx_sync_reg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) samp_reg <= 2'b11;
        else         samp_reg <= samp_next;
    end

    assign decide  = tick && (s_inc == 4'd9);
    assign bit_val = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_sync_reg) |
                     (samp_reg[1] & rx_sync_reg);
`else
    assign decide  = tick && (s_inc == 4'd8);
    assign bit_val = rx_sync_reg;
`endif

    assign perr = (PARITY == 1) ? ~xor_reg : (PARITY == 2) ? xor_reg : 1'b0;

    always_comb begin
        state_next   = state_reg;
        s_next       = tick ? s_inc : s_reg;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        xor_next     = xor_reg;
        ones_next    = ones_reg;
        brk_hi_next  = brk_hi_reg;
        push         = 1'b0;
        fe_next      = 1'b0;
        bd_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                s_next       = 4'd0;
                bit_cnt_next = 4'd0;
                if (rx_prev_reg && !rx_sync_reg) begin
                    state_next = START;
                    data_next  = '0;
                    xor_next   = 1'b0;
                    ones_next  = 1'b0;
                end
            end
            START: begin
                if (decide) state_next = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    data_next = {bit_val, data_reg[DATA_BITS-1:1]};
                    xor_next  = xor_reg ^ bit_val;
                    ones_next = ones_reg | bit_val;
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = 4'd0;
                        state_next   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            PAR: begin
                if (decide) begin
                    xor_next   = xor_reg ^ bit_val;
                    ones_next  = ones_reg | bit_val;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (!bit_val) begin
                        if (!ones_reg) begin
                            bd_next     = 1'b1;
                            brk_hi_next = 1'b0;
                            state_next  = BRK;
                        end else begin
                            fe_next    = 1'b1;
                            state_next = IDLE;
                        end
                    end else if (bit_cnt_reg == LAST_STOP) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
            BRK: begin
                // Leave only after the line stayed high across one whole tick interval
                if (!rx_sync_reg) begin
                    brk_hi_next = 1'b0;
                end else if (tick) begin
                    if (brk_hi_reg) state_next = IDLE;
                    brk_hi_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg         <= IDLE;
            acc_reg           <= 24'd0;
            s_reg             <= 4'd0;
            bit_cnt_reg       <= 4'd0;
            data_reg          <= '0;
            xor_reg           <= 1'b0;
            ones_reg          <= 1'b0;
            brk_hi_reg        <= 1'b0;
            framing_error_reg <= 1'b0;
            break_detect_reg  <= 1'b0;
        end else begin
            state_reg         <= state_next;
            acc_reg           <= acc_next;
            s_reg             <= s_next;
            bit_cnt_reg       <= bit_cnt_next;
            data_reg          <= data_next;
            xor_reg           <= xor_next;
            ones_reg          <= ones_next;
            brk_hi_reg        <= brk_hi_next;
            framing_error_reg <= fe_next;
            break_detect_reg  <= bd_next;
        end
    end

    logic [DATA_BITS:0]  mem [FIFO_DEPTH];
    logic [DATA_BITS:0]  head;
    logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]         level_reg, level_next;
    logic                full, pop, wr_en;

    assign full    = (level_reg == FULL_LVL);
    assign m_valid = (level_reg != '0);
    assign pop     = m_valid && m_ready;
    // A full FIFO still accepts the word when the head leaves in the same cycle
    assign wr_en   = push && (!full || pop);
    assign level_next = level_reg + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= {perr, data_reg};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg   <= level_next;
            overrun_reg <= push && full && !pop;
        end
    end

    assign head          = mem[rd_ptr_reg];
    assign m_data        = m_valid ? head[DATA_BITS-1:0] : '0;
    assign m_perr        = m_valid ? head[DATA_BITS] : 1'b0;
    assign fifo_level    = level_reg;
    assign framing_error = framing_error_reg;
    assign break_detect  = break_detect_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_uar_ovs.sv
// Self-checking bench for uar_ovs: instance A is 8N1 (depth 16), instance B is 8E2 (depth 4).
`timescale 1ns/1ps
module tb_uar_ovs;

    localparam real BIT_NS = 1.0e9 / 921600.0;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1;
    logic rdy_a = 1'b0, rdy_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic perr_a, perr_b, val_a, val_b;
    logic fe_a, fe_b, ov_a, ov_b, bd_a, bd_b;
    logic [4:0] lvl_a;
    logic [2:0] lvl_b;

    int n_chk = 0, n_pass = 0;
    logic [8:0] q_a[$], q_b[$], popped_a[$], popped_b[$];
    int exp_fe[2], exp_ov[2], exp_bd[2], obs_fe[2], obs_ov[2], obs_bd[2];
    bit rand_rdy = 0;

    uar_ovs #(.CLK_FREQ(100e6), .BAUD_RATE(921600.0), .DATA_BITS(8), .PARITY(0),
              .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .resetn(resetn), .rx(rx_a), .m_data(data_a), .m_perr(perr_a),
        .m_valid(val_a), .m_ready(rdy_a), .framing_error(fe_a), .overrun(ov_a),
        .break_detect(bd_a), .fifo_level(lvl_a));

    uar_ovs #(.CLK_FREQ(100e6), .BAUD_RATE(921600.0), .DATA_BITS(8), .PARITY(2),
              .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .resetn(resetn), .rx(rx_b), .m_data(data_b), .m_perr(perr_b),
        .m_valid(val_b), .m_ready(rdy_b), .framing_error(fe_b), .overrun(ov_b),
        .break_detect(bd_b), .fifo_level(lvl_b));

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rdy_a = 1'($urandom_range(0, 1));
            rdy_b = 1'($urandom_range(0, 1));
        end
    end

    // Per-cycle comparison against the model queues, handshake stability and pulse widths
    logic hold_a = 0, hold_b = 0, fe_pa = 0, fe_pb = 0, ov_pa = 0, ov_pb = 0, bd_pa = 0, bd_pb = 0;
    logic [8:0] prev_a, prev_b, w;
    always @(negedge clk) begin
        if (!resetn) begin
            hold_a = 0; hold_b = 0;
        end else begin
            if (hold_a && val_a) check("hold_a", {perr_a, data_a}, prev_a);
            if (hold_b && val_b) check("hold_b", {perr_b, data_b}, prev_b);
            if (val_a && rdy_a) begin
                check("pop_a_expected", int'(q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    w = q_a.pop_front();
                    check("pop_a", {perr_a, data_a}, w);
                end
                popped_a.push_back({perr_a, data_a});
            end
            if (val_b && rdy_b) begin
                check("pop_b_expected", int'(q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    w = q_b.pop_front();
                    check("pop_b", {perr_b, data_b}, w);
                end
                popped_b.push_back({perr_b, data_b});
            end
            hold_a = val_a && !rdy_a; prev_a = {perr_a, data_a};
            hold_b = val_b && !rdy_b; prev_b = {perr_b, data_b};
            if (fe_a) begin obs_fe[0]++; check("fe_a_single", fe_pa, 0); end
            if (fe_b) begin obs_fe[1]++; check("fe_b_single", fe_pb, 0); end
            if (ov_a) begin obs_ov[0]++; check("ov_a_single", ov_pa, 0); end
            if (ov_b) begin obs_ov[1]++; check("ov_b_single", ov_pb, 0); end
            if (bd_a) begin obs_bd[0]++; check("bd_a_single", bd_pa, 0); end
            if (bd_b) begin obs_bd[1]++; check("bd_b_single", bd_pb, 0); end
        end
        fe_pa = fe_a; fe_pb = fe_b; ov_pa = ov_a; ov_pb = ov_b; bd_pa = bd_a; bd_pb = bd_b;
    end

    // Frame-level model: outcome of a frame from its bits alone
    task automatic model_frame(input int inst, input logic [7:0] d, input logic p, input logic ok);
        logic [8:0] word;
        if (!ok) begin
            if (d == 8'd0 && p == 1'b0) exp_bd[inst]++;
            else exp_fe[inst]++;
            return;
        end
        word = {(inst == 1) ? ((^d) ^ p) : 1'b0, d};
        if (inst == 0) begin
            if (q_a.size() == 16) exp_ov[0]++;
            else q_a.push_back(word);
        end else begin
            if (q_b.size() == 4) exp_ov[1]++;
            else q_b.push_back(word);
        end
    endtask

    task automatic drive(input int inst, input logic v);
        if (inst == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic send_frame(input int inst, input logic [7:0] d, input logic p,
                              input logic [1:0] stops, input int glitch_bit, input bit gap);
        logic bits[$];
        int dec;
        logic ok;
        dec = -1;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (inst == 1) bits.push_back(p);
        for (int k = 0; k < ((inst == 1) ? 2 : 1); k++) begin
            bits.push_back(stops[k]);
            if (dec < 0 && !stops[k]) dec = bits.size() - 1;
        end
        ok = (dec < 0);
        if (ok) dec = bits.size() - 1;
        for (int i = 0; i < bits.size(); i++) begin
            drive(inst, bits[i]);
            if (i == glitch_bit) begin
                #(0.5 * BIT_NS + 5.0);
                drive(inst, ~bits[i]);
                #30;
                drive(inst, bits[i]);
                #(0.5 * BIT_NS - 35.0);
            end else if (i == dec) begin
                #(0.4 * BIT_NS);
                model_frame(inst, d, p, ok);
                #(0.6 * BIT_NS);
            end else begin
                #(BIT_NS);
            end
        end
        drive(inst, 1'b1);
        if (gap) #(BIT_NS);
    endtask

    task automatic set_ready(input logic a, input logic b);
        rand_rdy = 0;
        @(posedge clk);
        #2;
        rdy_a = a;
        rdy_b = b;
    endtask

    task automatic settle(input string tag);
        int n;
        n = 0;
        set_ready(1'b1, 1'b1);
        while ((val_a || val_b) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check({tag, "_drained"}, int'(n < 3000), 1);
        check({tag, "_lvl_a"}, lvl_a, 0);
        check({tag, "_lvl_b"}, lvl_b, 0);
        check({tag, "_model_a_empty"}, q_a.size(), 0);
        check({tag, "_model_b_empty"}, q_b.size(), 0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_fe_cnt%0d", tag, i), obs_fe[i], exp_fe[i]);
            check($sformatf("%s_ov_cnt%0d", tag, i), obs_ov[i], exp_ov[i]);
            check($sformatf("%s_bd_cnt%0d", tag, i), obs_bd[i], exp_bd[i]);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic p;
        logic [1:0] st;
        int ov0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_valid_a", val_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_perr_a", perr_a, 0);
        check("rst_level_a", lvl_a, 0);
        check("rst_pulses_a", {fe_a, ov_a, bd_a}, 0);
        check("rst_valid_b", val_b, 0);
        check("rst_level_b", lvl_b, 0);
        resetn = 1'b1;
        repeat (20) @(posedge clk);

        // Back-to-back 0x55, 0xA3 with a stalled consumer
        set_ready(1'b0, 1'b0);
        popped_a.delete();
        send_frame(0, 8'h55, 1'b0, 2'b11, -1, 1'b0);
        send_frame(0, 8'hA3, 1'b0, 2'b11, -1, 1'b1);
        @(negedge clk);
        check("b2b_level", lvl_a, 2);
        check("b2b_head", data_a, 8'h55);
        check("b2b_valid", val_a, 1);
        settle("b2b");
        check("b2b_pop_count", popped_a.size(), 2);
        if (popped_a.size() >= 2) begin
            check("b2b_first", popped_a[0], 9'h055);
            check("b2b_second", popped_a[1], 9'h0A3);
        end

        // Random 8N1 traffic with a random consumer
        rand_rdy = 1;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom_range(1, 255));
            st = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11;
            send_frame(0, d, 1'b0, st, -1, 1'b1);
        end
        settle("rand_a");

        // Framing error, then a long break, then a normal byte
        send_frame(0, 8'h3C, 1'b0, 2'b00, -1, 1'b1);
        rx_a = 1'b0;
        #(20.0 * BIT_NS);
        exp_bd[0]++;
        rx_a = 1'b1;
        #(2.0 * BIT_NS);
        popped_a.delete();
        send_frame(0, 8'h11, 1'b0, 2'b11, -1, 1'b1);
        settle("break");
        check("break_once", obs_bd[0], 1);
        if (popped_a.size() != 0) check("after_break", popped_a[popped_a.size() - 1], 9'h011);
        else check("after_break_count", popped_a.size(), 1);

        // Short low glitch on the idle line is rejected
        rx_a = 1'b0;
        #300;
        rx_a = 1'b1;
        #(2.0 * BIT_NS);
        check("glitch_no_word", val_a, 0);
        settle("glitch");

`ifdef UAR_OVS_MAJORITY_EN
        popped_a.delete();
        send_frame(0, 8'h5A, 1'b0, 2'b11, 3, 1'b1);
        settle("maj");
        check("maj_count", popped_a.size(), 1);
        if (popped_a.size() != 0) check("maj_word", popped_a[0], 9'h05A);
`endif

        // Reset asserted mid-frame with one word already buffered
        set_ready(1'b0, 1'b0);
        send_frame(0, 8'h42, 1'b0, 2'b11, -1, 1'b1);
        rx_a = 1'b0; #(BIT_NS);
        rx_a = 1'b0; #(BIT_NS);
        rx_a = 1'b1; #(BIT_NS);
        rx_a = 1'b1; #(BIT_NS);
        resetn = 1'b0;
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        check("midrst_valid", val_a, 0);
        check("midrst_data", data_a, 0);
        check("midrst_level", lvl_a, 0);
        check("midrst_pulses", {fe_a, ov_a, bd_a, perr_a}, 0);
        repeat (2) @(posedge clk);
        resetn = 1'b1;
        #(12.0 * BIT_NS);
        popped_a.delete();
        send_frame(0, 8'h96, 1'b0, 2'b11, -1, 1'b1);
        settle("postrst");
        check("postrst_count", popped_a.size(), 1);
        if (popped_a.size() != 0) check("postrst_word", popped_a[0], 9'h096);

        // Even parity: 0x07 with parity bit 0 is stored flagged
        set_ready(1'b0, 1'b0);
        send_frame(1, 8'h07, 1'b0, 2'b11, -1, 1'b1);
        @(negedge clk);
        check("par_head", data_b, 8'h07);
        check("par_perr", perr_b, 1);
        check("par_no_fe", obs_fe[1], 0);
        settle("par");

        // Random 8E2 traffic including bad parity, bad stop bits and zero frames
        rand_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            d = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            st = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send_frame(1, d, p, st, -1, 1'b1);
        end
        settle("rand_b");

        // Overrun: five bytes into a depth-4 FIFO with no consumer
        set_ready(1'b0, 1'b0);
        ov0 = obs_ov[1];
        popped_b.delete();
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send_frame(1, d, ^d, 2'b11, -1, 1'b0);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("ovr_level", lvl_b, 4);
        check("ovr_pulses", obs_ov[1] - ov0, 1);
        settle("ovr");
        check("ovr_drain_count", popped_b.size(), 4);
        for (int i = 0; i < 4 && i < popped_b.size(); i++)
            check($sformatf("ovr_drain%0d", i), popped_b[i], i + 1);

        // Second stop bit low
        send_frame(1, 8'h5C, ^(8'h5C), 2'b01, -1, 1'b1);
        settle("stop2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
